// File: rtl/key_pulse_gen_if.sv
// Button-side bundle of key_pulse_gen: raw active-low keys in, step pulses and held levels out.
interface key_pulse_gen_if;
    logic key_up_n;
    logic key_down_n;
    logic key_up;
    logic key_down;
    logic up_held;
    logic down_held;

    modport master (
        output key_up_n,
        output key_down_n,
        input  key_up,
        input  key_down,
        input  up_held,
        input  down_held
    );

    modport slave (
        input  key_up_n,
        input  key_down_n,
        output key_up,
        output key_down,
        output up_held,
        output down_held
    );
endinterface

// File: rtl/key_pulse_gen.sv
// Two-button conditioner: sync, debounce and press/auto-repeat FSM per key,
// producing one-cycle up/down step pulses for the breath-LED duty controller.
module key_pulse_gen #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DLY   = 25_000_000,
    parameter int REPEAT_PER   = 5_000_000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    key_pulse_gen_if.slave kif
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RP_W   = $clog2(RP_MAX);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DLY - 1);
    localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PER - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_e;

    // Index 0 is the up key, index 1 the down key.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      acc_q, acc_d;
    logic [1:0]      held_q, held_d;
    logic [1:0]      pulse_q, pulse_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [RP_W-1:0] rep_cnt_q [2];
    logic [RP_W-1:0] rep_cnt_d [2];
    state_e          state_q [2];
    state_e          state_d [2];
    logic            both_pressed;

    always_comb begin
        sync1_d = {kif.key_down_n, kif.key_up_n};
        sync2_d = sync1_q;
        acc_d   = acc_q;
        held_d  = acc_q;
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            // acc_q holds the accepted level as 1 = pressed, so compare against inverted sync.
            if (~sync2_q[k] != acc_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    acc_d[k] = ~acc_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign both_pressed = acc_q[0] & acc_q[1];

    always_comb begin
        pulse_d = 2'b00;
        for (int k = 0; k < 2; k++) begin
            state_d[k]   = state_q[k];
            rep_cnt_d[k] = rep_cnt_q[k];
            if (!acc_q[k]) begin
                state_d[k]   = IDLE;
                rep_cnt_d[k] = '0;
            end else if (both_pressed) begin
                // Conflicting keys: park both as fresh holds and stay silent.
                state_d[k]   = PRESSED;
                rep_cnt_d[k] = '0;
            end else begin
                case (state_q[k])
                    IDLE: begin
                        state_d[k]   = PRESSED;
                        rep_cnt_d[k] = '0;
                        pulse_d[k]   = 1'b1;
                    end
                    PRESSED: begin
                        if (!REPEAT_EN) begin
                            rep_cnt_d[k] = '0;
                        end else if (rep_cnt_q[k] == DLY_LAST) begin
                            state_d[k]   = REPEAT;
                            rep_cnt_d[k] = '0;
                            pulse_d[k]   = 1'b1;
                        end else begin
                            rep_cnt_d[k] = rep_cnt_q[k] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rep_cnt_q[k] == PER_LAST) begin
                            rep_cnt_d[k] = '0;
                            pulse_d[k]   = 1'b1;
                        end else begin
                            rep_cnt_d[k] = rep_cnt_q[k] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[k]   = IDLE;
                        rep_cnt_d[k] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            acc_q   <= 2'b00;
            held_q  <= 2'b00;
            pulse_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k]  <= '0;
                rep_cnt_q[k] <= '0;
                state_q[k]   <= IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k]  <= db_cnt_d[k];
                rep_cnt_q[k] <= rep_cnt_d[k];
                state_q[k]   <= state_d[k];
            end
        end
    end

    assign kif.key_up    = pulse_q[0];
    assign kif.key_down  = pulse_q[1];
    assign kif.up_held   = held_q[0];
    assign kif.down_held = held_q[1];
endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen: expected pulse cycles queued at stimulus time,
// matched against the DUT pulses by a negedge monitor.
module tb_key_pulse_gen;
    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   q_up0[$];
    int   q_dn0[$];
    int   q_up1[$];
    int   q_dn1[$];

    key_pulse_gen_if if0 ();
    key_pulse_gen_if if1 ();

    key_pulse_gen #(.DEBOUNCE_CYC(DB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_EN(1'b1))
        u0 (.clk(clk), .rst(rst), .kif(if0));
    key_pulse_gen #(.DEBOUNCE_CYC(DB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_EN(1'b0))
        u1 (.clk(clk), .rst(rst), .kif(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, req, cyc);
        end
    endtask

    task automatic mon_ch(input string tag, input logic p, input int sz, input int front,
                          output logic pop);
        pop = 1'b0;
        if (sz != 0 && front < cyc) begin
            cmp({tag, "_missed_pulse_cycle"}, -1, front);
            pop = 1'b1;
        end else if (p) begin
            cmp({tag, "_pulse_cycle"}, cyc, (sz != 0) ? front : -1);
            pop = (sz != 0 && front == cyc);
        end
    endtask

    always @(negedge clk) begin
        logic pop;
        if (rst) begin
            mon_ch("up0", if0.key_up, q_up0.size(), (q_up0.size() != 0) ? q_up0[0] : -1, pop);
            if (pop) void'(q_up0.pop_front());
            mon_ch("dn0", if0.key_down, q_dn0.size(), (q_dn0.size() != 0) ? q_dn0[0] : -1, pop);
            if (pop) void'(q_dn0.pop_front());
            mon_ch("up1", if1.key_up, q_up1.size(), (q_up1.size() != 0) ? q_up1[0] : -1, pop);
            if (pop) void'(q_up1.pop_front());
            mon_ch("dn1", if1.key_down, q_dn1.size(), (q_dn1.size() != 0) ? q_dn1[0] : -1, pop);
            if (pop) void'(q_dn1.pop_front());
            if (if0.key_up) cmp("exclusive_u0", int'(if0.key_down), 0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic chk_queues(input string tag);
        cmp({tag, "_up0_left"}, q_up0.size(), 0);
        cmp({tag, "_dn0_left"}, q_dn0.size(), 0);
        cmp({tag, "_up1_left"}, q_up1.size(), 0);
        cmp({tag, "_dn1_left"}, q_dn1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int c;
        if0.key_up_n = 1'b1; if0.key_down_n = 1'b1;
        if1.key_up_n = 1'b1; if1.key_down_n = 1'b1;
        step(3);
        cmp("rst_key_up", int'(if0.key_up), 0);
        cmp("rst_key_down", int'(if0.key_down), 0);
        cmp("rst_up_held", int'(if0.up_held), 0);
        cmp("rst_down_held", int'(if0.down_held), 0);
        rst = 1'b1;
        step(5);

        // 1: long hold of up with auto-repeat, then release
        t0 = cyc;
        if0.key_up_n = 1'b0;
        q_up0.push_back(t0 + 7);
        q_up0.push_back(t0 + 17);
        for (c = t0 + 20; c <= t0 + 40 + DB + 2; c += PER) q_up0.push_back(c);
        wait_to(t0 + 6);
        cmp("t1_up_held_before", int'(if0.up_held), 0);
        wait_to(t0 + 7);
        cmp("t1_up_held_at_press", int'(if0.up_held), 1);
        wait_to(t0 + 40);
        if0.key_up_n = 1'b1;
        wait_to(t0 + 46);
        cmp("t1_up_held_until_accept", int'(if0.up_held), 1);
        wait_to(t0 + 47);
        cmp("t1_up_held_released", int'(if0.up_held), 0);
        wait_to(t0 + 60);
        chk_queues("t1");

        // 2: short glitches on down never get accepted
        for (int r = 0; r < 4; r++) begin
            if0.key_down_n = 1'b0;
            step(3);
            if0.key_down_n = 1'b1;
            step(2);
            cmp("t2_down_held", int'(if0.down_held), 0);
        end
        step(10);
        cmp("t2_down_held_final", int'(if0.down_held), 0);
        chk_queues("t2");

        // 3: repeat disabled, one pulse per press
        t0 = cyc;
        if1.key_down_n = 1'b0;
        q_dn1.push_back(t0 + 7);
        wait_to(t0 + 50);
        cmp("t3_down_held", int'(if1.down_held), 1);
        if1.key_down_n = 1'b1;
        wait_to(t0 + 65);
        cmp("t3_down_held_released", int'(if1.down_held), 0);
        chk_queues("t3");

        // 4: both keys held suppress all pulses; down resumes as a fresh hold
        t0 = cyc;
        if0.key_up_n = 1'b0;
        q_up0.push_back(t0 + 7);
        q_up0.push_back(t0 + 17);
        q_up0.push_back(t0 + 20);
        q_up0.push_back(t0 + 23);
        q_up0.push_back(t0 + 26);
        wait_to(t0 + 20);
        if0.key_down_n = 1'b0;
        wait_to(t0 + 26);
        cmp("t4_down_held_before", int'(if0.down_held), 0);
        wait_to(t0 + 27);
        cmp("t4_down_held", int'(if0.down_held), 1);
        cmp("t4_up_held", int'(if0.up_held), 1);
        wait_to(t0 + 40);
        if0.key_up_n = 1'b1;
        for (c = t0 + 56; c <= t0 + 60 + DB + 2; c += PER) q_dn0.push_back(c);
        wait_to(t0 + 60);
        if0.key_down_n = 1'b1;
        wait_to(t0 + 80);
        chk_queues("t4");

        // 5: async reset in the middle of auto-repeat while key stays held
        t0 = cyc;
        if0.key_up_n = 1'b0;
        q_up0.push_back(t0 + 7);
        q_up0.push_back(t0 + 17);
        wait_to(t0 + 20);
        cmp("t5_pulse_before_rst", int'(if0.key_up), 1);
        rst = 1'b0;
        #1;
        cmp("t5_rst_key_up", int'(if0.key_up), 0);
        cmp("t5_rst_up_held", int'(if0.up_held), 0);
        cmp("t5_rst_key_down", int'(if0.key_down), 0);
        wait_to(t0 + 22);
        rst = 1'b1;
        q_up0.push_back(t0 + 22 + DB + 3);
        wait_to(t0 + 30);
        if0.key_up_n = 1'b1;
        wait_to(t0 + 50);
        chk_queues("t5");

        // 6: bouncing contact settles low, one clean press pulse
        for (int i = 0; i < 10; i++) begin
            if0.key_up_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        t0 = cyc;
        if0.key_up_n = 1'b0;
        q_up0.push_back(t0 + 7);
        wait_to(t0 + 10);
        if0.key_up_n = 1'b1;
        wait_to(t0 + 30);
        chk_queues("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
